// File: rtl/oc8051_cxrom_fetch_pkg.sv
// Shared constants and types for the oc8051 code-ROM prefetch stage.
// Widths derived from DEPTH live here so the queue and the top agree on them.
package oc8051_fetch_pkg;
    localparam int FETCH_BYTES     = 4;
    localparam int MAX_INSTR_BYTES = 3;
    localparam int ADDR_W          = 16;

    typedef logic [7:0]        byte_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Count must hold the value DEPTH itself, hence one extra bit.
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/oc8051_cxrom_fetch_if.sv
// Bundle of ROM bus and decoder-side signals of the oc8051 prefetch stage.
// load_valid is a single-cycle request that is always taken (no ready); pop_len is taken only when pop_len <= instr_avail.
interface oc8051_cxrom_fetch_if;
    import oc8051_fetch_pkg::*;

    addr_t       cxrom_addr;
    logic [31:0] cxrom_data_out;
    logic        fetch_en;
    logic        load_valid;
    addr_t       load_addr;
    logic [1:0]  pop_len;
    logic [23:0] instr_window;
    logic [1:0]  instr_avail;
    addr_t       instr_pc;
    logic        pop_err;

    modport master (
        output cxrom_addr, instr_window, instr_avail, instr_pc, pop_err,
        input  cxrom_data_out, fetch_en, load_valid, load_addr, pop_len
    );

    modport slave (
        input  cxrom_addr, instr_window, instr_avail, instr_pc, pop_err,
        output cxrom_data_out, fetch_en, load_valid, load_addr, pop_len
    );
endinterface

// File: rtl/oc8051_cxrom_fetch_byte_queue.sv
// Circular byte queue: 4-byte write port, 0-3 byte pop, 3-byte peek window.
// Window bytes beyond the current fill level read as zero.
module oc8051_byte_queue
    import oc8051_fetch_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = count_w(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           wr_en,
    input  logic [8*FETCH_BYTES-1:0]       wr_data,
    input  logic [1:0]                     pop_len,
    output logic [CNT_W-1:0]               count,
    output logic [8*MAX_INSTR_BYTES-1:0]   window,
    output logic [1:0]                     avail
);
    byte_t            mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < FETCH_BYTES; i++)
                mem[wr_ptr + PTR_W'(i)] <= wr_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_W'(FETCH_BYTES);
            rd_ptr <= rd_ptr + PTR_W'(pop_len);
            count  <= count - CNT_W'(pop_len) + (wr_en ? CNT_W'(FETCH_BYTES) : CNT_W'(0));
        end
    end

    always_comb begin
        avail = (count >= CNT_W'(MAX_INSTR_BYTES)) ? 2'd3 : count[1:0];
        window = '0;
        for (int i = 0; i < MAX_INSTR_BYTES; i++)
            if (i < int'(avail))
                window[8*i +: 8] = mem[rd_ptr + PTR_W'(i)];
    end
endmodule

// File: rtl/oc8051_cxrom_fetch.sv
// oc8051 prefetch stage: drives the code ROM address, queues fetched bytes and
// feeds the decoder a 3-byte window; load_valid flushes and redirects fetch.
module oc8051_cxrom_fetch
    import oc8051_fetch_pkg::*;
#(
    parameter int    DEPTH    = 8,
    parameter addr_t RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    oc8051_cxrom_fetch_if.master bus
);
    localparam int CNT_W = count_w(DEPTH);

    logic [CNT_W-1:0] count;
    logic [1:0]       avail;
    logic [23:0]      window;
    addr_t            fetch_addr;
    addr_t            instr_pc;
    logic             pop_err_q;
    logic             fill;
    logic             pop_ok;
    logic             pop_bad;
    logic [1:0]       q_pop;

    // Fill looks at the pre-pop count, so a concurrent pop can never cause overflow.
    always_comb begin
        fill    = bus.fetch_en && !bus.load_valid &&
                  ((CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_BYTES));
        pop_ok  = !bus.load_valid && (bus.pop_len <= avail);
        pop_bad = !bus.load_valid && (bus.pop_len > avail);
        q_pop   = pop_ok ? bus.pop_len : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_addr <= RESET_PC;
            instr_pc   <= RESET_PC;
            pop_err_q  <= 1'b0;
        end else if (bus.load_valid) begin
            fetch_addr <= bus.load_addr;
            instr_pc   <= bus.load_addr;
            pop_err_q  <= 1'b0;
        end else begin
            if (fill)
                fetch_addr <= fetch_addr + addr_t'(FETCH_BYTES);
            if (pop_ok)
                instr_pc <= instr_pc + addr_t'(bus.pop_len);
            pop_err_q <= pop_bad;
        end
    end

    oc8051_byte_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.load_valid),
        .wr_en   (fill),
        .wr_data (bus.cxrom_data_out),
        .pop_len (q_pop),
        .count   (count),
        .window  (window),
        .avail   (avail)
    );

    assign bus.cxrom_addr   = fetch_addr;
    assign bus.instr_window = window;
    assign bus.instr_avail  = avail;
    assign bus.instr_pc     = instr_pc;
    assign bus.pop_err      = pop_err_q;
endmodule

// File: tb/tb_oc8051_cxrom_fetch.sv
// Directed bench for oc8051_cxrom_fetch against a ROM returning ROM[a] = a[7:0].
module tb_oc8051_cxrom_fetch;
    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    oc8051_cxrom_fetch_if bus();

    oc8051_cxrom_fetch #(.DEPTH(8), .RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] a1, a2, a3;
    assign a1 = bus.cxrom_addr + 16'd1;
    assign a2 = bus.cxrom_addr + 16'd2;
    assign a3 = bus.cxrom_addr + 16'd3;
    assign bus.cxrom_data_out = {a3[7:0], a2[7:0], a1[7:0], bus.cxrom_addr[7:0]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [15:0] addr, input logic [1:0] av,
                               input logic [23:0] win, input logic [15:0] pc, input logic perr);
        check({tag, ".cxrom_addr"},   32'(bus.cxrom_addr),   32'(addr));
        check({tag, ".instr_avail"},  32'(bus.instr_avail),  32'(av));
        check({tag, ".instr_window"}, 32'(bus.instr_window), 32'(win));
        check({tag, ".instr_pc"},     32'(bus.instr_pc),     32'(pc));
        check({tag, ".pop_err"},      32'(bus.pop_err),      32'(perr));
    endtask

    initial begin
        rst            = 1'b1;
        bus.fetch_en   = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_addr  = 16'h0000;
        bus.pop_len    = 2'd0;
        tick();
        tick();
        check_state("reset", 16'h0000, 2'd0, 24'h000000, 16'h0000, 1'b0);

        // Fill after reset release
        rst = 1'b0;
        tick();
        check_state("fill1", 16'h0004, 2'd3, 24'h020100, 16'h0000, 1'b0);
        tick();
        check_state("fill2", 16'h0008, 2'd3, 24'h020100, 16'h0000, 1'b0);
        tick();
        check_state("full_hold", 16'h0008, 2'd3, 24'h020100, 16'h0000, 1'b0);

        // Pops 3, 1, 2 from a full queue
        bus.pop_len = 2'd3;
        tick();
        check_state("pop3", 16'h0008, 2'd3, 24'h050403, 16'h0003, 1'b0);
        bus.pop_len = 2'd1;
        tick();
        check_state("pop1", 16'h0008, 2'd3, 24'h060504, 16'h0004, 1'b0);
        bus.pop_len = 2'd2;
        tick();
        check_state("pop2", 16'h000C, 2'd3, 24'h080706, 16'h0006, 1'b0);

        // Redirect with a concurrent pop that must be ignored
        bus.pop_len    = 2'd3;
        bus.load_valid = 1'b1;
        bus.load_addr  = 16'h1235;
        tick();
        check_state("redir", 16'h1235, 2'd0, 24'h000000, 16'h1235, 1'b0);
        bus.load_valid = 1'b0;
        bus.pop_len    = 2'd0;
        tick();
        check_state("redir_fill", 16'h1239, 2'd3, 24'h373635, 16'h1235, 1'b0);

        // Illegal pop on an empty queue
        bus.fetch_en   = 1'b0;
        bus.load_valid = 1'b1;
        tick();
        check_state("empty", 16'h1235, 2'd0, 24'h000000, 16'h1235, 1'b0);
        bus.load_valid = 1'b0;
        bus.pop_len    = 2'd2;
        tick();
        check_state("pop_err_on", 16'h1235, 2'd0, 24'h000000, 16'h1235, 1'b1);
        bus.pop_len = 2'd0;
        tick();
        check_state("pop_err_off", 16'h1235, 2'd0, 24'h000000, 16'h1235, 1'b0);

        // Address wrap through 16'hFFFF
        bus.fetch_en   = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_addr  = 16'hFFFE;
        tick();
        check_state("wrap_redir", 16'hFFFE, 2'd0, 24'h000000, 16'hFFFE, 1'b0);
        bus.load_valid = 1'b0;
        tick();
        check_state("wrap_fill", 16'h0002, 2'd3, 24'h00FFFE, 16'hFFFE, 1'b0);
        bus.pop_len = 2'd3;
        tick();
        check_state("wrap_pop", 16'h0006, 2'd3, 24'h030201, 16'h0001, 1'b0);
        tick();
        check_state("wrap_pop2", 16'h0006, 2'd2, 24'h000504, 16'h0004, 1'b0);
        bus.pop_len = 2'd0;
        tick();
        check_state("count6", 16'h000A, 2'd3, 24'h060504, 16'h0004, 1'b0);

        // Reset overrides a simultaneous redirect and pop
        rst            = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_addr  = 16'h4321;
        bus.pop_len    = 2'd1;
        tick();
        check_state("mid_reset", 16'h0000, 2'd0, 24'h000000, 16'h0000, 1'b0);
        rst            = 1'b0;
        bus.load_valid = 1'b0;
        bus.pop_len    = 2'd0;
        tick();
        check_state("post_reset", 16'h0004, 2'd3, 24'h020100, 16'h0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
